// File: rtl/ama_riscv_imem_loader.sv
// Boot-time IMEM loader: turns a byte stream (count header, little-endian
// payload words, XOR checksum) into IMEM port A writes and keeps the core in
// reset until a complete image has been written and its checksum verified.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HDR_LO | waiting for the low byte of the word count
// HDR_HI | waiting for the high byte; count is range-checked here
// DATA   | assembling payload words, one IMEM write per 4th byte
// CSUM   | waiting for the checksum byte
// DONE   | image good, core released; sticky until rst
// ERR    | bad header or checksum, core held in reset; sticky until rst

module ama_riscv_imem_loader #(
    parameter int IMEM_AW = 14,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_ena,
    output logic [3:0]         imem_wea,
    output logic [IMEM_AW-1:0] imem_addra,
    output logic [31:0]        imem_dina,
    output logic               core_rst,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Largest legal word count: the whole IMEM
    localparam int unsigned CAP = 32'd1 << IMEM_AW;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [IMEM_AW:0]   word_idx_q, word_idx_d;
    logic [7:0]         xor_q, xor_d;
    logic [23:0]        word_q, word_d;
    logic               ena_q, ena_d;
    logic [3:0]         wea_q, wea_d;
    logic [IMEM_AW-1:0] addra_q, addra_d;
    logic [31:0]        dina_q, dina_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [15:0]        hdr_n;
    logic               xfer;

    assign rx_ready = !rst && (state_q == HDR_LO || state_q == HDR_HI ||
                               state_q == DATA   || state_q == CSUM);
    assign xfer     = rx_valid && rx_ready;
    assign hdr_n    = {rx_data, cnt_q[7:0]};

    // Next-state and output computation; write strobes default low every cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        xor_d      = xor_q;
        word_d     = word_q;
        ena_d      = 1'b0;
        wea_d      = 4'h0;
        addra_d    = addra_q;
        dina_d     = dina_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        if (xfer) begin
            case (state_q)
                HDR_LO: begin
                    cnt_d   = CNT_W'(rx_data);
                    state_d = HDR_HI;
                end
                HDR_HI: begin
                    cnt_d = CNT_W'(hdr_n);
                    if (hdr_n == 16'd0 || 32'(hdr_n) > CAP) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    xor_d      = xor_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            ena_d      = 1'b1;
                            wea_d      = 4'hF;
                            addra_d    = word_idx_q[IMEM_AW-1:0];
                            dina_d     = {rx_data, word_q};
                            word_idx_d = word_idx_q + 1'b1;
                            if ((32'(word_idx_q) + 32'd1) == 32'(cnt_q)) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
                CSUM: begin
                    if (rx_data == xor_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset; IMEM contents are never cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HDR_LO;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            xor_q      <= '0;
            word_q     <= '0;
            ena_q      <= 1'b0;
            wea_q      <= 4'h0;
            addra_q    <= '0;
            dina_q     <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            xor_q      <= xor_d;
            word_q     <= word_d;
            ena_q      <= ena_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign imem_ena   = ena_q;
    assign imem_wea   = wea_q;
    assign imem_addra = addra_q;
    assign imem_dina  = dina_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ama_riscv_imem_loader.sv
// Bench for the IMEM loader: expected IMEM writes are queued as bytes are
// sent and popped by a write monitor; each test checks final status inline.

module tb_ama_riscv_imem_loader;

    localparam int IMEM_AW = 14;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               imem_ena;
    logic [3:0]         imem_wea;
    logic [IMEM_AW-1:0] imem_addra;
    logic [31:0]        imem_dina;
    logic               core_rst;
    logic               done;
    logic               err;

    typedef struct packed {
        logic [IMEM_AW-1:0] addr;
        logic [31:0]        data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  n_writes = 0;
    int  stalls   = 0;

    ama_riscv_imem_loader #(.IMEM_AW(IMEM_AW), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_ena   (imem_ena),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Write monitor / scoreboard, sampling away from the active edge
    always @(negedge clk) begin
        if (imem_ena) begin
            wr_t e;
            checks++;
            n_writes++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addra, imem_dina);
            end else begin
                e = exp_q.pop_front();
                if ({imem_wea, imem_addra, imem_dina} !== {4'hF, e.addr, e.data}) begin
                    errors++;
                    $display("FAIL imem_write: got wea=%h addr=%h data=%h, required wea=f addr=%h data=%h",
                             imem_wea, imem_addra, imem_dina, e.addr, e.data);
                end
            end
        end else begin
            checks++;
            if (imem_wea !== 4'h0) begin
                errors++;
                $display("FAIL wea_idle: got %h, required 0", imem_wea);
            end
        end
        checks++;
        if (done === 1'b1 && err === 1'b1) begin
            errors++;
            $display("FAIL done_err_exclusive: got done=1 err=1, required not both");
        end
    end

    initial begin
        #(900000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles; returns just before the
    // transfer edge, so a back-to-back call lands on the following cycle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got rx_ready=%b, required 1", rx_ready);
        end
    endtask

    task automatic finish_stream();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Header + payload (queued as expected writes); returns the checksum
    task automatic send_image(input logic [31:0] words[$], input int max_gap, output logic [7:0] cs);
        logic [15:0] n;
        n  = 16'(words.size());
        cs = 8'h00;
        send_byte(n[7:0], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        send_byte(n[15:8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        for (int w = 0; w < words.size(); w++) begin
            exp_q.push_back({IMEM_AW'(w), words[w]});
            for (int b = 0; b < 4; b++) begin
                logic [7:0] by;
                by = words[w][8*b +: 8];
                cs = cs ^ by;
                send_byte(by, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_ena, imem_wea, imem_addra, imem_dina} !== '0) begin
            errors++;
            $display("FAIL reset_imem: got ena=%b wea=%h addr=%h data=%h, required all 0",
                     imem_ena, imem_wea, imem_addra, imem_dina);
        end
        checks++;
        if ({core_rst, done, err, rx_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_status: got core_rst/done/err/rx_ready=%b, required 1000",
                     {core_rst, done, err, rx_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", rx_ready);
        end
    endtask

    task automatic test_load(input int max_gap, input string name);
        logic [31:0] words[$];
        logic [7:0]  cs;
        apply_reset();
        words    = '{32'h12345678, 32'hDEADBEEF};
        n_writes = 0;
        stalls   = 0;
        send_image(words, max_gap, cs);
        checks++;
        if (cs !== 8'h2A) begin
            errors++;
            $display("FAIL %s_cs_model: got %h, required 2a", name, cs);
        end
        send_byte(cs, max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
        checks++;
        if ({done, core_rst} !== 2'b01) begin
            errors++;
            $display("FAIL %s_before_done: got done/core_rst=%b, required 01", name, {done, core_rst});
        end
        finish_stream();
        checks++;
        if ({done, err, core_rst, rx_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_done: got done/err/core_rst/rx_ready=%b, required 1000",
                     name, {done, err, core_rst, rx_ready});
        end
        checks++;
        if (n_writes != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes, %0d pending, required 2 and 0",
                     name, n_writes, exp_q.size());
        end
        if (max_gap == 0) begin
            checks++;
            if (stalls != 0) begin
                errors++;
                $display("FAIL %s_no_stall: got %0d stall cycles, required 0", name, stalls);
            end
        end
        // Sticky: extra idle cycles and a stray valid change nothing
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({done, err, core_rst} !== 3'b100) begin
            errors++;
            $display("FAIL %s_done_sticky: got done/err/core_rst=%b, required 100", name, {done, err, core_rst});
        end
    endtask

    task automatic test_bad_checksum();
        logic [31:0] words[$];
        logic [7:0]  cs;
        apply_reset();
        words    = '{32'h00000001};
        n_writes = 0;
        send_image(words, 0, cs);
        send_byte(8'h00, 0);
        finish_stream();
        checks++;
        if ({done, err, core_rst, rx_ready} !== 4'b0110) begin
            errors++;
            $display("FAIL bad_csum_status: got done/err/core_rst/rx_ready=%b, required 0110",
                     {done, err, core_rst, rx_ready});
        end
        checks++;
        if (n_writes != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bad_csum_writes: got %0d writes, required 1", n_writes);
        end
    endtask

    task automatic test_bad_header(input logic [7:0] lo, input logic [7:0] hi, input string name);
        apply_reset();
        n_writes = 0;
        send_byte(lo, 0);
        send_byte(hi, 0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL %s_err_early: got err=%b, required 0", name, err);
        end
        finish_stream();
        checks++;
        if ({done, err, core_rst, rx_ready} !== 4'b0110) begin
            errors++;
            $display("FAIL %s_status: got done/err/core_rst/rx_ready=%b, required 0110",
                     name, {done, err, core_rst, rx_ready});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n_writes != 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes err=%b, required 0 writes err=1", name, n_writes, err);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] words[$];
        logic [7:0]  cs;
        apply_reset();
        n_writes = 0;
        exp_q.push_back({IMEM_AW'(0), 32'hA1B2C3D4});
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hD4, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        send_byte(8'h77, 0);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_ena, imem_wea, imem_addra, imem_dina, core_rst, done, err, rx_ready}
                !== {1'b0, 4'h0, IMEM_AW'(0), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_outputs: got ena=%b wea=%h addr=%h data=%h core_rst=%b done=%b err=%b rdy=%b, required reset values",
                     imem_ena, imem_wea, imem_addra, imem_dina, core_rst, done, err, rx_ready);
        end
        checks++;
        if (n_writes != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_writes: got %0d writes, required 1", n_writes);
        end
        rst = 1'b0;
        words = '{32'hCAFEF00D};
        send_image(words, 0, cs);
        send_byte(cs, 0);
        finish_stream();
        checks++;
        if ({done, err, core_rst} !== 3'b100 || n_writes != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_reload: got done/err/core_rst=%b writes=%0d, required 100 and 2",
                     {done, err, core_rst}, n_writes);
        end
    endtask

    task automatic test_capacity();
        logic [31:0] words[$];
        logic [7:0]  cs;
        apply_reset();
        n_writes = 0;
        for (int i = 0; i < (1 << IMEM_AW); i++) words.push_back(32'(i));
        send_image(words, 0, cs);
        send_byte(cs, 0);
        checks++;
        if (imem_addra !== IMEM_AW'((1 << IMEM_AW) - 1)) begin
            errors++;
            $display("FAIL cap_last_addr: got %h, required %h", imem_addra, IMEM_AW'((1 << IMEM_AW) - 1));
        end
        finish_stream();
        checks++;
        if ({done, err, core_rst} !== 3'b100 || n_writes != (1 << IMEM_AW) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL cap_done: got done/err/core_rst=%b writes=%0d, required 100 and %0d",
                     {done, err, core_rst}, n_writes, 1 << IMEM_AW);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_load(0, "load_contig");
        test_load(5, "load_gaps");
        test_bad_checksum();
        test_bad_header(8'h00, 8'h00, "hdr_zero");
        test_bad_header(8'h01, 8'h40, "hdr_over");
        test_reset_mid_load();
        test_capacity();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
